// File: rtl/sync_dual_rr_merge.sv
`timescale 1ns/1ps
// sync_dual_rr_merge
// Clocked round-robin merge of N dual-rail four-phase request channels onto a
// single dual-rail output channel. Each channel is synchronized into the clock
// domain. A channel is only considered DATA or NULL once its synchronized word
// has been identical on two consecutive samples, which filters out rail skew.
// The chosen word is captured, so the output never follows live input. The
// round-robin pointer moves past a channel only after its full handshake
// (DATA, COMP=1, NULL, COMP=0) completes.
//
// Ports
//   clk          rising-edge clock
//   init         synchronous active-high reset
//   dual_in      N channels of W dual-rail digits, channel i at [i*2W +: 2W]
//   dual_comp    per-channel completion: 0 asks for DATA, 1 asks for NULL
//   outfinal     registered merged dual-rail output word
//   outfinalCOMP consumer completion: 0 ready for DATA, 1 ready for NULL
//   grant        one-hot current owner of the output, 0 when idle
//   illegal      one-cycle pulse per cycle a synchronized digit reads 11
module sync_dual_rr_merge #(
  parameter int N           = 4,
  parameter int W           = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             init,
  input  logic [N*2*W-1:0] dual_in,
  output logic [N-1:0]     dual_comp,
  output logic [2*W-1:0]   outfinal,
  input  logic             outfinalCOMP,
  output logic [N-1:0]     grant,
  output logic             illegal
);

  localparam int CW = 2 * W;
  localparam int DW = N * CW;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2
  } stateT;

  // True when any digit of the word has both rails high.
  function automatic logic hasIllegalDigit(input logic [CW-1:0] word);
    logic bad;
    bad = 1'b0;
    for (int d = 0; d < W; d++) begin
      bad = bad | (word[2*d] & word[2*d+1]);
    end
    return bad;
  endfunction

  // True when every digit of the word has exactly one rail high.
  function automatic logic isCompleteData(input logic [CW-1:0] word);
    logic ok;
    ok = 1'b1;
    for (int d = 0; d < W; d++) begin
      ok = ok & (word[2*d] ^ word[2*d+1]);
    end
    return ok;
  endfunction

  logic [DW-1:0]          dinSync [SYNC_STAGES];
  logic [DW-1:0]          dinPrev;
  logic [SYNC_STAGES-1:0] ocSync;
  logic [DW-1:0]          dinCur;
  logic                   ocS;

  logic [N-1:0]  chData;
  logic [N-1:0]  chNull;
  logic [N-1:0]  chBad;

  stateT         state;
  stateT         stateNext;
  logic [PW-1:0] rrPtr;
  logic [PW-1:0] ownerReg;

  logic          pickFound;
  logic [PW-1:0] pickIdx;
  logic [CW-1:0] pickWord;

  logic [CW-1:0] outNext;
  logic [N-1:0]  grantNext;
  logic [N-1:0]  compNext;
  logic [PW-1:0] ptrNext;
  logic [PW-1:0] ownerNext;

  // Input synchronizers plus one extra sample that feeds the skew filter.
  always_ff @(posedge clk) begin
    if (init) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        dinSync[s] <= {DW{1'b0}};
      end
      dinPrev <= {DW{1'b0}};
      ocSync  <= {SYNC_STAGES{1'b0}};
    end else begin
      dinSync[0] <= dual_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        dinSync[s] <= dinSync[s-1];
      end
      dinPrev <= dinSync[SYNC_STAGES-1];
      ocSync  <= {ocSync[SYNC_STAGES-2:0], outfinalCOMP};
    end
  end

  assign dinCur = dinSync[SYNC_STAGES-1];
  assign ocS    = ocSync[SYNC_STAGES-1];

  // Per-channel qualification: stable complete DATA, stable NULL, or illegal.
  always_comb begin
    chData = {N{1'b0}};
    chNull = {N{1'b0}};
    chBad  = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      chBad[i]  = hasIllegalDigit(dinCur[i*CW +: CW]);
      chData[i] = (dinCur[i*CW +: CW] == dinPrev[i*CW +: CW])
                  && isCompleteData(dinCur[i*CW +: CW]);
      chNull[i] = (dinCur[i*CW +: CW] == dinPrev[i*CW +: CW])
                  && (dinCur[i*CW +: CW] == {CW{1'b0}});
    end
  end

  // Round-robin pick: first DATA channel at or after rrPtr, wrapping at N.
  always_comb begin
    int scan;
    scan      = 0;
    pickFound = 1'b0;
    pickIdx   = {PW{1'b0}};
    pickWord  = {CW{1'b0}};
    for (int k = 0; k < N; k++) begin
      scan = int'(rrPtr) + k;
      if (scan >= N) begin
        scan = scan - N;
      end else begin
        scan = scan + 0;
      end
      for (int j = 0; j < N; j++) begin
        if (!pickFound && (scan == j) && chData[j]) begin
          pickFound = 1'b1;
          pickIdx   = PW'(j);
          pickWord  = dinCur[j*CW +: CW];
        end else begin
          pickFound = pickFound;
        end
      end
    end
  end

  // Handshake sequencing: next state and next registered outputs.
  always_comb begin
    stateNext = state;
    outNext   = outfinal;
    grantNext = grant;
    compNext  = dual_comp;
    ptrNext   = rrPtr;
    ownerNext = ownerReg;
    case (state)
      IDLE: begin
        outNext   = {CW{1'b0}};
        grantNext = {N{1'b0}};
        compNext  = {N{1'b0}};
        if (!ocS && pickFound) begin
          outNext   = pickWord;
          grantNext = {{(N-1){1'b0}}, 1'b1} << pickIdx;
          ownerNext = pickIdx;
          stateNext = SEND;
        end else begin
          stateNext = IDLE;
        end
      end
      SEND: begin
        // Output holds the captured word until the consumer signals it took it.
        if (ocS) begin
          outNext   = {CW{1'b0}};
          compNext  = grant;
          stateNext = ACK;
        end else begin
          stateNext = SEND;
        end
      end
      ACK: begin
        // Both the source and the consumer must be back at NULL before release.
        if (chNull[ownerReg] && !ocS) begin
          compNext  = {N{1'b0}};
          grantNext = {N{1'b0}};
          ptrNext   = (ownerReg == PW'(N-1)) ? {PW{1'b0}} : ownerReg + PW'(1);
          stateNext = IDLE;
        end else begin
          stateNext = ACK;
        end
      end
      default: begin
        outNext   = {CW{1'b0}};
        grantNext = {N{1'b0}};
        compNext  = {N{1'b0}};
        stateNext = IDLE;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk) begin
    if (init) begin
      state     <= IDLE;
      rrPtr     <= {PW{1'b0}};
      ownerReg  <= {PW{1'b0}};
      outfinal  <= {CW{1'b0}};
      grant     <= {N{1'b0}};
      dual_comp <= {N{1'b0}};
      illegal   <= 1'b0;
    end else begin
      state     <= stateNext;
      rrPtr     <= ptrNext;
      ownerReg  <= ownerNext;
      outfinal  <= outNext;
      grant     <= grantNext;
      dual_comp <= compNext;
      illegal   <= |chBad;
    end
  end

endmodule

// File: tb/tb_sync_dual_rr_merge.sv
`timescale 1ns/1ps
// Bench for sync_dual_rr_merge (N=4, W=1, SYNC_STAGES=2). A transaction-level
// reference (pin history, current owner, acknowledged flag, pointer) predicts
// every output on every edge; directed scenarios add literal expectations.
module tb_sync_dual_rr_merge;

  localparam int N  = 4;
  localparam int W  = 1;
  localparam int S  = 2;
  localparam int CW = 2 * W;
  localparam int DW = N * CW;

  logic          clk = 1'b0;
  logic          init;
  logic [DW-1:0] dualIn;
  logic [N-1:0]  dualComp;
  logic [CW-1:0] outFinal;
  logic          oc;
  logic [N-1:0]  grant;
  logic          illegal;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sync_dual_rr_merge #(.N(N), .W(W), .SYNC_STAGES(S)) dut (
    .clk          (clk),
    .init         (init),
    .dual_in      (dualIn),
    .dual_comp    (dualComp),
    .outfinal     (outFinal),
    .outfinalCOMP (oc),
    .grant        (grant),
    .illegal      (illegal)
  );

  // Reference state
  logic [DW-1:0] hIn[$];
  logic          hOc[$];
  int            mOwner;
  int            mPtr;
  bit            mAcked;
  logic [CW-1:0] mOut;
  logic [N-1:0]  mComp;
  logic [N-1:0]  mGrant;
  logic          mIll;
  logic [CW-1:0] prevOut = {CW{1'b0}};
  int            grantLog[$];
  int            srcPhase[N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    hIn.delete();
    hOc.delete();
    for (int k = 0; k <= S; k++) begin
      hIn.push_back({DW{1'b0}});
      hOc.push_back(1'b0);
    end
    mOwner = -1;
    mPtr   = 0;
    mAcked = 1'b0;
    mOut   = {CW{1'b0}};
    mComp  = {N{1'b0}};
    mGrant = {N{1'b0}};
    mIll   = 1'b0;
    grantLog.delete();
  endtask

  // One clock edge of the reference. hIn[0] is the newest pin sample; the
  // arbiter sees the sample S edges old and filters it against S+1 edges old.
  task automatic modelEdge();
    logic [DW-1:0] cur, prv;
    logic          ocCur;
    bit            isData[N];
    bit            isNull[N];
    bit            anyBad;
    if (init) begin
      modelReset();
      return;
    end
    cur    = hIn[S-1];
    prv    = hIn[S];
    ocCur  = hOc[S-1];
    anyBad = 1'b0;
    for (int i = 0; i < N; i++) begin
      logic [CW-1:0] c, p;
      logic [1:0]    dig;
      int            good;
      c    = cur[i*CW +: CW];
      p    = prv[i*CW +: CW];
      good = 0;
      for (int d = 0; d < W; d++) begin
        dig = c[2*d +: 2];
        if (dig == 2'b11) anyBad = 1'b1;
        if (dig == 2'b01 || dig == 2'b10) good++;
      end
      isData[i] = (c == p) && (good == W);
      isNull[i] = (c == p) && (c == {CW{1'b0}});
    end
    mIll = anyBad;
    if (mOwner < 0) begin
      if (!ocCur) begin
        for (int k = 0; k < N; k++) begin
          int i;
          i = (mPtr + k) % N;
          if (mOwner < 0 && isData[i]) begin
            mOwner = i;
            mOut   = cur[i*CW +: CW];
            mGrant = {{(N-1){1'b0}}, 1'b1} << i;
            grantLog.push_back(i);
          end
        end
      end
    end else if (!mAcked) begin
      if (ocCur) begin
        mAcked = 1'b1;
        mOut   = {CW{1'b0}};
        mComp  = {{(N-1){1'b0}}, 1'b1} << mOwner;
      end
    end else begin
      if (isNull[mOwner] && !ocCur) begin
        mComp  = {N{1'b0}};
        mGrant = {N{1'b0}};
        mPtr   = (mOwner + 1) % N;
        mOwner = -1;
        mAcked = 1'b0;
      end
    end
    hIn.push_front(dualIn);
    void'(hIn.pop_back());
    hOc.push_front(oc);
    void'(hOc.pop_back());
  endtask

  // Advance one edge and compare every output against the reference.
  task automatic tick();
    @(posedge clk);
    modelEdge();
    #1;
    check("outfinal", 32'(outFinal), 32'(mOut));
    check("grant", 32'(grant), 32'(mGrant));
    check("dual_comp", 32'(dualComp), 32'(mComp));
    check("illegal", 32'(illegal), 32'(mIll));
    if (prevOut != {CW{1'b0}} && outFinal != {CW{1'b0}}) begin
      check("null_spacer", 32'(outFinal), 32'(prevOut));
    end
    prevOut = outFinal;
  endtask

  task automatic doReset();
    init = 1'b1;
    tick();
    init = 1'b0;
  endtask

  function automatic logic [CW-1:0] randData();
    logic [CW-1:0] w;
    for (int d = 0; d < W; d++) begin
      w[2*d +: 2] = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
    end
    return w;
  endfunction

  // Well-behaved four-phase sources and consumer, with optional noise.
  task automatic driveAgents(input bit alwaysReq, input bit allowIllegal);
    for (int i = 0; i < N; i++) begin
      case (srcPhase[i])
        0: begin
          if (dualComp[i] == 1'b0 && (alwaysReq || $urandom_range(0, 3) == 0)) begin
            if (allowIllegal && $urandom_range(0, 15) == 0) begin
              dualIn[i*CW +: CW] = {CW{1'b1}};
              srcPhase[i] = 2;
            end else begin
              dualIn[i*CW +: CW] = randData();
              srcPhase[i] = 1;
            end
          end
        end
        1: begin
          if (dualComp[i]) begin
            dualIn[i*CW +: CW] = {CW{1'b0}};
            srcPhase[i] = 0;
          end else if (!alwaysReq && $urandom_range(0, 19) == 0) begin
            dualIn[i*CW +: CW] = randData();
          end
        end
        default: begin
          dualIn[i*CW +: CW] = {CW{1'b0}};
          srcPhase[i] = 0;
        end
      endcase
    end
    if (outFinal != {CW{1'b0}} && !oc && (alwaysReq || $urandom_range(0, 2) == 0)) begin
      oc = 1'b1;
    end else if (outFinal == {CW{1'b0}} && oc && (alwaysReq || $urandom_range(0, 2) == 0)) begin
      oc = 1'b0;
    end
  endtask

  task automatic clearAgents();
    for (int i = 0; i < N; i++) srcPhase[i] = 0;
    dualIn = {DW{1'b0}};
    oc     = 1'b0;
  endtask

  initial begin
    int cyc;
    init = 1'b1;
    clearAgents();

    // 1: reset while ch1 holds DATA, then ch1 is granted after S+2 edges.
    dualIn = 8'b0000_0100;
    tick();
    check("t1_rst_out", 32'(outFinal), 32'd0);
    check("t1_rst_grant", 32'(grant), 32'd0);
    check("t1_rst_comp", 32'(dualComp), 32'd0);
    init = 1'b0;
    repeat (3) tick();
    check("t1_not_early", 32'(grant), 32'd0);
    tick();
    check("t1_grant", 32'(grant), 32'h2);
    check("t1_out", 32'(outFinal), 32'h1);

    // 2: single transfer on ch2, then pointer moves to 3.
    clearAgents();
    doReset();
    dualIn = 8'b0010_0000;
    repeat (3) tick();
    check("t2_not_early", 32'(grant), 32'd0);
    tick();
    check("t2_grant", 32'(grant), 32'h4);
    check("t2_out", 32'(outFinal), 32'h2);
    oc = 1'b1;
    repeat (2) tick();
    check("t2_hold", 32'(outFinal), 32'h2);
    tick();
    check("t2_ack_out", 32'(outFinal), 32'd0);
    check("t2_ack_comp", 32'(dualComp), 32'h4);
    dualIn = 8'b0000_0000;
    oc = 1'b0;
    repeat (3) tick();
    check("t2_wait_null", 32'(dualComp), 32'h4);
    tick();
    check("t2_rel_comp", 32'(dualComp), 32'd0);
    check("t2_rel_grant", 32'(grant), 32'd0);
    dualIn = 8'b1000_0001;
    repeat (4) tick();
    check("t2_ptr3_grant", 32'(grant), 32'h8);
    check("t2_ptr3_out", 32'(outFinal), 32'h2);

    // 3: fairness with all four channels requesting continuously.
    clearAgents();
    doReset();
    cyc = 0;
    while (grantLog.size() < 5 && cyc < 600) begin
      tick();
      driveAgents(1'b1, 1'b0);
      cyc++;
    end
    check("t3_complete", 32'(grantLog.size() >= 5), 32'd1);
    for (int k = 0; k < 5; k++) begin
      if (k < grantLog.size()) check("t3_order", 32'(grantLog[k]), 32'(k % 4));
    end

    // 4: consumer stall in IDLE, then in SEND.
    clearAgents();
    oc = 1'b1;
    dualIn = 8'b0000_0100;
    doReset();
    repeat (10) tick();
    check("t4_idle_stall", 32'(grant), 32'd0);
    oc = 1'b0;
    repeat (2) tick();
    check("t4_not_early", 32'(grant), 32'd0);
    tick();
    check("t4_grant", 32'(grant), 32'h2);
    repeat (20) tick();
    check("t4_send_stall", 32'(outFinal), 32'h1);

    // 5: ch0 illegal, ch3 granted instead.
    clearAgents();
    doReset();
    dualIn = 8'b0100_0011;
    repeat (3) tick();
    check("t5_illegal", 32'(illegal), 32'd1);
    tick();
    check("t5_grant", 32'(grant), 32'h8);
    check("t5_out", 32'(outFinal), 32'h1);
    check("t5_illegal_repeat", 32'(illegal), 32'd1);

    // 6: reset during SEND abandons the transfer; ch3 is re-arbitrated.
    init = 1'b1;
    tick();
    init = 1'b0;
    check("t6_out", 32'(outFinal), 32'd0);
    check("t6_grant", 32'(grant), 32'd0);
    check("t6_comp", 32'(dualComp), 32'd0);
    check("t6_illegal", 32'(illegal), 32'd0);
    repeat (4) tick();
    check("t6_regrant", 32'(grant), 32'h8);

    // Randomized traffic with noise, data changes and occasional resets.
    clearAgents();
    doReset();
    for (int c = 0; c < 4000; c++) begin
      tick();
      driveAgents(1'b0, 1'b1);
      init = ($urandom_range(0, 699) == 0) ? 1'b1 : 1'b0;
    end
    init = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
